// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx: queues GPIO word writes in a small FIFO and sends each word as 4 UART bytes, LSB byte first.
// Define GPIO_UART_PARITY_EN to append an even-parity bit to every byte (8E1 instead of 8N1).
module gpio_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = FIFO_AW + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef GPIO_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          byte_q, byte_d;
    logic [31:0]         shreg_q, shreg_d;
    logic                tx_q, tx_d;
    logic [7:0]          byte_nx;

    logic [31:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q;
    logic                push, pop, empty, baud_done;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    // A pop in the same cycle never makes room for a write that sees full.
    assign push      = wr_en && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign baud_done = (baud_q == BAUD_LAST);

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || !empty;
    assign overflow = ovf_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
            if (wr_en && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    state_d = START;
                    shreg_d = mem_q[rptr_q];
                    byte_d  = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef GPIO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef GPIO_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_d = STOP;
                    baud_d  = '0;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q == 2'd3) begin
                        state_d = IDLE;
                    end else begin
                        state_d = START;
                        byte_d  = byte_q + 1'b1;
                        shreg_d = shreg_q >> 8;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // tx is derived from the next state so the line changes on the same edge as the FSM.
        byte_nx = shreg_d[7:0];
        tx_d    = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = byte_nx[bit_d];
`ifdef GPIO_UART_PARITY_EN
            PARITY:  tx_d = ^byte_nx;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Bench for gpio_uart_tx: directed writes feed an expected-byte queue; a UART decoder on tx pops and compares.
`timescale 1ns/1ps
module tb_gpio_uart_tx;
    localparam int CPB = 4;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        wr_en   = 1'b0;
    logic [31:0] wr_data = '0;
    logic        tx, busy, full, overflow;

    int          n_vec = 0;
    int          n_bad = 0;
    int          epoch = 0;
    logic [7:0]  exp_q[$];

    gpio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .busy(busy), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // UART decoder: samples each bit in its middle cycle, compares against the queue head.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       st, stp;
        int         ep;
`ifdef GPIO_UART_PARITY_EN
        logic       par;
`endif
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                ep = epoch;
                repeat (CPB/2) @(negedge clk);
                st = tx;
                for (int j = 0; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = tx;
                end
`ifdef GPIO_UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                par = tx;
`endif
                repeat (CPB) @(negedge clk);
                stp = tx;
                if (ep == epoch) begin
                    check("start_bit", 32'(st), 32'd0);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", 32'(b), 32'(e));
`ifdef GPIO_UART_PARITY_EN
                        check("parity_bit", 32'(par), 32'(^e));
`endif
                    end
                    check("stop_bit", 32'(stp), 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] w3 [6];
        logic [31:0] w4 [5];
        w3 = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3, 32'hF0F1F2F3};
        w4 = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344};

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // Single word: start bit one edge after the push, busy drops 160 cycles later
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'h44332211;
        push_word(32'h44332211);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("t2_tx_at_k", 32'(tx), 32'd1);
        check("t2_busy_at_k", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t2_tx_at_k1", 32'(tx), 32'd0);
        repeat (159) @(posedge clk);
        @(negedge clk);
        check("t2_busy_k160", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t2_busy_k161", 32'(busy), 32'd0);
        drain(400);

        // Burst of six writes: five accepted, sixth dropped
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) check("t3_full_after5", 32'(full), 32'd1);
            wr_en = 1'b1; wr_data = w3[i];
            if (i < 5) push_word(w3[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("t3_full_after6", 32'(full), 32'd1);
        check("t3_overflow", 32'(overflow), 32'd1);
        drain(2000);

        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        check("t3_overflow_cleared", 32'(overflow), 32'd0);

        // Full FIFO with a write on the exact cycle IDLE pops: write is lost
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = w4[i];
            push_word(w4[i]);
        end
        @(negedge clk);
        wr_en = 1'b0;
        check("t4_full", 32'(full), 32'd1);
        check("t4_no_overflow", 32'(overflow), 32'd0);
        repeat (157) @(posedge clk);
        @(negedge clk);
        check("t4_full_pre_pop", 32'(full), 32'd1);
        wr_en = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("t4_full_post_pop", 32'(full), 32'd0);
        check("t4_overflow", 32'(overflow), 32'd1);
        drain(2000);

        // Reset during DATA of byte 2 discards the frame and the queued word
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'h55667788;
        push_word(32'h55667788);
        @(negedge clk);
        wr_data = 32'h99AABBCC;
        push_word(32'h99AABBCC);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (90) @(posedge clk);
        @(negedge clk);
        epoch++;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_full", 32'(full), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        repeat (60) @(negedge clk);
        check("t5_tx_quiet", 32'(tx), 32'd1);
        check("t5_busy_quiet", 32'(busy), 32'd0);
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'hCAFEF00D;
        push_word(32'hCAFEF00D);
        @(negedge clk);
        wr_en = 1'b0;
        drain(400);

`ifdef GPIO_UART_PARITY_EN
        // Parity frame: 44 cycles per byte, word of 176 cycles
        @(negedge clk);
        wr_en = 1'b1; wr_data = 32'h00000007;
        push_word(32'h00000007);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_tx_start", 32'(tx), 32'd0);
        repeat (175) @(posedge clk);
        @(negedge clk);
        check("t6_busy_k176", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t6_busy_k177", 32'(busy), 32'd0);
        drain(400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
